// File: rtl/mips_pkg.sv
// Shared types for the five-stage MIPS32 subset core:
// opcodes, ALU control and the inter-stage pipeline bundles.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctrl_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    alu_ctrl_e   alu_ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc_plus4;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [4:0]  dst;
    logic [31:0] alu_out;
    logic [31:0] wdata;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  dst;
    logic [31:0] alu_out;
    logic [31:0] rdata;
  } mem_wb_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// Operand forwarding selects, load-use stall and
// control-flow flushes for the E stage.
module mips_hazard_unit
  import mips_pkg::*;
(
  input  logic [4:0] i_rs_d,
  input  logic [4:0] i_rt_d,
  input  logic [4:0] i_rs_e,
  input  logic [4:0] i_rt_e,
  input  logic [4:0] i_dst_e,
  input  logic       i_lw_e,
  input  logic       i_rw_m,
  input  logic [4:0] i_dst_m,
  input  logic       i_rw_w,
  input  logic [4:0] i_dst_w,
  input  logic       i_taken,
  input  logic       i_jump,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic       o_stall,
  output logic       o_flush_d,
  output logic       o_flush_e
);

  logic w_m_ok;
  logic w_w_ok;
  logic w_lw_use;

  assign w_m_ok = i_rw_m && (i_dst_m != 5'd0);
  assign w_w_ok = i_rw_w && (i_dst_w != 5'd0);

  assign o_fwd_a =
    (w_m_ok && i_dst_m == i_rs_e) ? FWD_M :
    (w_w_ok && i_dst_w == i_rs_e) ? FWD_W : FWD_RF;
  assign o_fwd_b =
    (w_m_ok && i_dst_m == i_rt_e) ? FWD_M :
    (w_w_ok && i_dst_w == i_rt_e) ? FWD_W : FWD_RF;

  assign w_lw_use = i_lw_e && (i_dst_e != 5'd0) &&
    (i_dst_e == i_rs_d || i_dst_e == i_rt_d);

  // A taken branch overrides both the stall and a jump in D.
  assign o_stall   = w_lw_use && !i_taken;
  assign o_flush_e = w_lw_use || i_taken;
  assign o_flush_d = i_taken || (i_jump && !w_lw_use);

endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file; written on the falling edge so a
// same-cycle decode read already sees the writeback value.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] r_mem [32];

  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (i_we && i_wa != 5'd0) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/mips_core.sv
// Five-stage pipelined MIPS32 subset core with inline
// decode and ALU; regfile and hazard logic are sub-modules.
module mips_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] readData,
  output logic [31:0] pc,
  output logic [31:0] aluOut,
  output logic [31:0] writeData,
  output logic        memWrite,
  output logic        regWriteW
);

  logic [31:0] r_pc;
  if_id_t      r_if_id;
  id_ex_t      r_id_ex;
  ex_mem_t     r_ex_mem;
  mem_wb_t     r_mem_wb;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic [31:0] w_ins;
  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_jtarget;
  logic        w_jump;
  id_ex_t      w_id_ex;
  logic [31:0] w_result_w;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic        w_stall;
  logic        w_flush_d;
  logic        w_flush_e;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu;
  logic        w_taken;
  logic [31:0] w_btarget;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_ins      = r_if_id.instr;
  assign w_op       = w_ins[31:26];
  assign w_fn       = w_ins[5:0];
  assign w_rs       = w_ins[25:21];
  assign w_rt       = w_ins[20:16];
  assign w_rd       = w_ins[15:11];
  assign w_jtarget  = {r_if_id.pc_plus4[31:28], w_ins[25:0], 2'b00};
  assign w_result_w = r_mem_wb.mem_to_reg ? r_mem_wb.rdata : r_mem_wb.alu_out;

  mips_regfile u_regfile (
    .i_clk   (clk),
    .i_reset (reset),
    .i_we    (r_mem_wb.reg_write),
    .i_wa    (r_mem_wb.dst),
    .i_wd    (w_result_w),
    .i_ra1   (w_rs),
    .i_ra2   (w_rt),
    .o_rd1   (w_rd1),
    .o_rd2   (w_rd2)
  );

  always_comb begin
    w_id_ex          = '0;
    w_jump           = 1'b0;
    w_id_ex.alu_ctrl = ALU_ADD;
    w_id_ex.rs       = w_rs;
    w_id_ex.rt       = w_rt;
    w_id_ex.rd1      = w_rd1;
    w_id_ex.rd2      = w_rd2;
    w_id_ex.imm      = sext16(w_ins[15:0]);
    w_id_ex.pc_plus4 = r_if_id.pc_plus4;
    unique case (1'b1)
      (w_op == OP_RTYPE): begin
        w_id_ex.dst       = w_rd;
        w_id_ex.reg_write = 1'b1;
        unique case (w_fn)
          FN_ADD:  w_id_ex.alu_ctrl = ALU_ADD;
          FN_SUB:  w_id_ex.alu_ctrl = ALU_SUB;
          FN_AND:  w_id_ex.alu_ctrl = ALU_AND;
          FN_OR:   w_id_ex.alu_ctrl = ALU_OR;
          FN_SLT:  w_id_ex.alu_ctrl = ALU_SLT;
          default: w_id_ex.reg_write = 1'b0;
        endcase
      end
      (w_op == OP_LW): begin
        w_id_ex.dst        = w_rt;
        w_id_ex.reg_write  = 1'b1;
        w_id_ex.mem_to_reg = 1'b1;
        w_id_ex.alu_src    = 1'b1;
      end
      (w_op == OP_SW): begin
        w_id_ex.mem_write = 1'b1;
        w_id_ex.alu_src   = 1'b1;
      end
      (w_op == OP_BEQ): begin
        w_id_ex.branch   = 1'b1;
        w_id_ex.alu_ctrl = ALU_SUB;
      end
      (w_op == OP_ADDI): begin
        w_id_ex.dst       = w_rt;
        w_id_ex.reg_write = 1'b1;
        w_id_ex.alu_src   = 1'b1;
      end
      (w_op == OP_J): w_jump = 1'b1;
      default: ;
    endcase
  end

  mips_hazard_unit u_hazard (
    .i_rs_d    (w_rs),
    .i_rt_d    (w_rt),
    .i_rs_e    (r_id_ex.rs),
    .i_rt_e    (r_id_ex.rt),
    .i_dst_e   (r_id_ex.dst),
    .i_lw_e    (r_id_ex.mem_to_reg),
    .i_rw_m    (r_ex_mem.reg_write),
    .i_dst_m   (r_ex_mem.dst),
    .i_rw_w    (r_mem_wb.reg_write),
    .i_dst_w   (r_mem_wb.dst),
    .i_taken   (w_taken),
    .i_jump    (w_jump),
    .o_fwd_a   (w_fwd_a),
    .o_fwd_b   (w_fwd_b),
    .o_stall   (w_stall),
    .o_flush_d (w_flush_d),
    .o_flush_e (w_flush_e)
  );

  assign w_src_a =
    (w_fwd_a == FWD_M) ? r_ex_mem.alu_out :
    (w_fwd_a == FWD_W) ? w_result_w : r_id_ex.rd1;
  assign w_src_b =
    (w_fwd_b == FWD_M) ? r_ex_mem.alu_out :
    (w_fwd_b == FWD_W) ? w_result_w : r_id_ex.rd2;
  assign w_alu_b = r_id_ex.alu_src ? r_id_ex.imm : w_src_b;

  always_comb begin
    w_alu = '0;
    unique case (r_id_ex.alu_ctrl)
      ALU_ADD: w_alu = w_src_a + w_alu_b;
      ALU_SUB: w_alu = w_src_a - w_alu_b;
      ALU_AND: w_alu = w_src_a & w_alu_b;
      ALU_OR:  w_alu = w_src_a | w_alu_b;
      ALU_SLT: w_alu = {31'd0, $signed(w_src_a) < $signed(w_alu_b)};
      default: w_alu = '0;
    endcase
  end

  assign w_taken   = r_id_ex.branch && (w_src_a == w_src_b);
  assign w_btarget = r_id_ex.pc_plus4 + {r_id_ex.imm[29:0], 2'b00};

  assign w_pc_next =
    w_taken ? w_btarget :
    w_stall ? r_pc :
    w_jump  ? w_jtarget : w_pc_plus4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= '0;
      r_if_id  <= '0;
      r_id_ex  <= '0;
      r_ex_mem <= '0;
      r_mem_wb <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_flush_d) r_if_id <= '0;
      else if (!w_stall) r_if_id <= '{instr: instr, pc_plus4: w_pc_plus4};
      r_id_ex  <= w_flush_e ? '0 : w_id_ex;
      r_ex_mem <= '{
        reg_write:  r_id_ex.reg_write,
        mem_to_reg: r_id_ex.mem_to_reg,
        mem_write:  r_id_ex.mem_write,
        dst:        r_id_ex.dst,
        alu_out:    w_alu,
        wdata:      w_src_b
      };
      r_mem_wb <= '{
        reg_write:  r_ex_mem.reg_write,
        mem_to_reg: r_ex_mem.mem_to_reg,
        dst:        r_ex_mem.dst,
        alu_out:    r_ex_mem.alu_out,
        rdata:      readData
      };
    end
  end

  assign pc        = r_pc;
  assign aluOut    = r_ex_mem.alu_out;
  assign writeData = r_ex_mem.wdata;
  assign memWrite  = r_ex_mem.mem_write;
  assign regWriteW = r_mem_wb.reg_write;

endmodule

// File: tb/tb_mips_core.sv
// Scoreboard bench for mips_core: program in imem, expected
// pc trace / stores / M-W observations queued and compared.
module tb_mips_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] readData;
  logic [31:0] pc;
  logic [31:0] aluOut;
  logic [31:0] writeData;
  logic        memWrite;
  logic        regWriteW;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];

  always #5 clk = ~clk;

  mips_core dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .readData  (readData),
    .pc        (pc),
    .aluOut    (aluOut),
    .writeData (writeData),
    .memWrite  (memWrite),
    .regWriteW (regWriteW)
  );

  assign instr    = imem[pc[7:2]];
  assign readData = dmem[aluOut[7:2]];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) dmem[i] <= '0;
      dmem[1] <= 32'h55;
    end else if (memWrite) begin
      dmem[aluOut[7:2]] <= writeData;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  typedef struct {
    int          c;
    bit          k;
    logic [31:0] v;
  } ob_t;

  st_t         st_q[$];
  ob_t         ob_q[$];
  logic [31:0] pc_q[$];

  logic [31:0] prog [28] = '{
    32'h20020001, 32'h20030002, 32'h00432020, 32'hAC040000,
    32'h8C050004, 32'h00A53020, 32'hAC060008, 32'h08000009,
    32'hAC020040, 32'h10000002, 32'hAC020044, 32'hAC020048,
    32'h00023822, 32'h00E2402A, 32'hAC07000C, 32'hAC080010,
    32'h10430005, 32'h00864824, 32'h00865025, 32'h20EB0001,
    32'hAC090014, 32'hAC0A0018, 32'hAC0B001C, 32'h00436021,
    32'h20000005, 32'hAC0C0020, 32'hAC000024, 32'h0800001B
  };

  logic [31:0] pc_head [13] = '{
    32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
    32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C
  };

  initial begin
    int   extra;
    int   wcount;
    st_t  s;
    ob_t  o;

    extra  = 0;
    wcount = 0;
    for (int i = 0; i < 64; i++) imem[i] = (i < 28) ? prog[i] : 32'h0;

    foreach (pc_head[i]) pc_q.push_back(pc_head[i]);
    for (int n = 13; n <= 28; n++) pc_q.push_back(32'h30 + 32'(4 * (n - 13)));
    for (int n = 29; n <= 40; n++) pc_q.push_back((n % 2) ? 32'h70 : 32'h6C);

    st_q.push_back('{32'h00, 32'h3});
    st_q.push_back('{32'h08, 32'hAA});
    st_q.push_back('{32'h0C, 32'hFFFFFFFF});
    st_q.push_back('{32'h10, 32'h1});
    st_q.push_back('{32'h14, 32'h2});
    st_q.push_back('{32'h18, 32'hAB});
    st_q.push_back('{32'h1C, 32'h0});
    st_q.push_back('{32'h20, 32'h0});
    st_q.push_back('{32'h24, 32'h0});

    ob_q.push_back('{3, 1'b0, 32'h1});
    ob_q.push_back('{4, 1'b0, 32'h2});
    ob_q.push_back('{4, 1'b1, 32'h1});
    ob_q.push_back('{5, 1'b0, 32'h3});
    ob_q.push_back('{5, 1'b1, 32'h1});
    ob_q.push_back('{9, 1'b0, 32'hAA});

    reset = 1'b1;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_alu", aluOut, 32'h0);
    chk("rst_wd", writeData, 32'h0);
    chk("rst_mw", {31'd0, memWrite}, 32'h0);
    chk("rst_rw", {31'd0, regWriteW}, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      chk("pc", pc, pc_q.pop_front());
      if (memWrite) begin
        if (st_q.size() > 0) begin
          s = st_q.pop_front();
          chk("st_addr", aluOut, s.a);
          chk("st_data", writeData, s.d);
        end else begin
          extra++;
        end
      end
      while (ob_q.size() > 0 && ob_q[0].c == n) begin
        o = ob_q.pop_front();
        if (o.k) chk("regw", {31'd0, regWriteW}, o.v);
        else chk("alu_m", aluOut, o.v);
      end
      wcount += int'(regWriteW);
    end
    chk("st_left", 32'(st_q.size()), 32'h0);
    chk("st_extra", 32'(extra), 32'h0);
    chk("regw_cnt", 32'(wcount), 32'd11);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_pc", pc, 32'h14);
    chk("mid_alu", aluOut, 32'h3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_alu", aluOut, 32'h0);
    chk("arst_wd", writeData, 32'h0);
    chk("arst_mw", {31'd0, memWrite}, 32'h0);
    chk("arst_rw", {31'd0, regWriteW}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_pc0", pc, 32'h0);
    @(posedge clk);
    #1;
    chk("rel_pc1", pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
